ps2_key_decoder: RTL

Converts the PS/2 set-2 scan-code byte stream from the PS/2 receiver into the per-key press/release pulse packet (keys_t) that drives camera control. It tracks which of the 12 camera keys are held and suppresses typematic repeats, so each physical press yields exactly one press pulse. It also gives one release pulse per physical release. Sits directly between the PS/2 byte receiver and the camera controller.

---
 rtl/ps2_key_decoder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder for the 12 camera keys: tracks the held state of each key,
// drops typematic repeats, and emits one-cycle press/release pulses per key.
package ps2_key_decoder_pkg;
    typedef struct packed {
        logic [1:0] d;
        logic [1:0] a;
        logic [1:0] e;
        logic [1:0] q;
        logic [1:0] w;
        logic [1:0] s;
        logic [1:0] l;
        logic [1:0] j;
        logic [1:0] o;
        logic [1:0] u;
        logic [1:0] i;
        logic [1:0] k;
    } keys_t;
endpackage

module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       code_valid,
    input  logic [7:0] code,
    output keys_t      keys,
    output logic [11:0] held,
    output logic       seq_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [11:0]      held_r, held_s;
    logic [23:0]      keys_r, keys_s;
    logic             seq_err_r, seq_err_s;
    logic [4:0]       map_s;
    logic             hit_s;
    logic [3:0]       idx_s;
    logic [4:0]       press_bit_s;
    logic [4:0]       release_bit_s;

    // Returns {hit, key index}; the index matches the bit position in held (k=0 .. d=11).
    function automatic logic [4:0] map_code(input logic [7:0] c);
        case (c)
            8'h23:   map_code = {1'b1, 4'd11};
            8'h1C:   map_code = {1'b1, 4'd10};
            8'h24:   map_code = {1'b1, 4'd9};
            8'h15:   map_code = {1'b1, 4'd8};
            8'h1D:   map_code = {1'b1, 4'd7};
            8'h1B:   map_code = {1'b1, 4'd6};
            8'h4B:   map_code = {1'b1, 4'd5};
            8'h3B:   map_code = {1'b1, 4'd4};
            8'h44:   map_code = {1'b1, 4'd3};
            8'h3C:   map_code = {1'b1, 4'd2};
            8'h43:   map_code = {1'b1, 4'd1};
            8'h42:   map_code = {1'b1, 4'd0};
            default: map_code = {1'b0, 4'd0};
        endcase
    endfunction

    assign map_s         = map_code(code);
    assign hit_s         = map_s[4];
    assign idx_s         = map_s[3:0];
    assign press_bit_s   = {idx_s, 1'b0};
    assign release_bit_s = {idx_s, 1'b1};

    // Next-state, held-set update and pulse generation for one received byte or idle cycle.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        held_s    = held_r;
        keys_s    = 24'd0;
        seq_err_s = 1'b0;
        if (code_valid) begin
            cnt_s = {CNT_W{1'b0}};
            case (state_r)
                IDLE: begin
                    if (code == CODE_BRK) begin
                        state_s = BRK;
                    end else if (code == CODE_EXT) begin
                        state_s = EXT;
                    end else if (hit_s && !held_r[idx_s]) begin
                        held_s[idx_s]        = 1'b1;
                        keys_s[press_bit_s]  = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
                BRK: begin
                    state_s = IDLE;
                    if (hit_s && held_r[idx_s]) begin
                        held_s[idx_s]         = 1'b0;
                        keys_s[release_bit_s] = 1'b1;
                    end else begin
                        held_s = held_r;
                    end
                end
                EXT: begin
                    if (code == CODE_BRK) begin
                        state_s = EXT_BRK;
                    end else begin
                        state_s = IDLE;
                    end
                end
                EXT_BRK: state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end else if (state_r != IDLE) begin
            // A stalled prefix is abandoned so a lost byte cannot turn the next make into a break.
            if (cnt_r == CNT_LAST) begin
                state_s   = IDLE;
                cnt_s     = {CNT_W{1'b0}};
                seq_err_s = 1'b1;
            end else begin
                cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_s = {CNT_W{1'b0}};
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            held_r    <= 12'd0;
            keys_r    <= 24'd0;
            seq_err_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            held_r    <= held_s;
            keys_r    <= keys_s;
            seq_err_r <= seq_err_s;
        end
    end

    assign keys    = keys_r;
    assign held    = held_r;
    assign seq_err = seq_err_r;

endmodule
